// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr: N:1 registered datapath selector.
// Picks one channel per cycle, either by explicit select (mode 0) or by
// round-robin over requesting channels (mode 1), and captures the winner's
// word into a single output register.
//
// Handshake: the output slot offers Y while Y_valid=1; a word transfers on
// every rising edge where Y_valid && Y_ready. The slot may load a new word
// whenever it is empty or is being drained in the same cycle, so back-to-back
// transfers run at one word per cycle. On the producer side grant[k] is the
// acknowledge: a producer holds req[k]/I[k] until it sees grant[k] high.
module mux_nx1_rr #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [WIDTH-1:0]   Y,
  output logic               Y_valid,
  output logic [SELW-1:0]    Y_ch,
  output logic [N-1:0]       grant,
  input  logic               Y_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    s,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] I
);

  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic [SELW-1:0]  y_ch_q, y_ch_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load_en;
  logic             has_win;
  logic             fire;
  logic [SELW-1:0]  winner;
  logic [WIDTH-1:0] win_data;

  assign load_en = !y_valid_q || Y_ready;
  // A capture happens only when the slot can take a word and nobody is resetting it.
  assign fire    = !reset && load_en && has_win;

  // Winner selection: explicit select, or first requester at/after ptr (wrapping).
  always_comb begin
    int idx;
    has_win = 1'b0;
    winner  = '0;
    idx     = 0;
    if (!mode) begin
      // s >= N never matches any k, so an out-of-range select yields no winner.
      for (int k = 0; k < N; k++) begin
        if ((int'(s) == k) && req[k]) begin
          has_win = 1'b1;
          winner  = SELW'(k);
        end
      end
    end else begin
      // Scan from the farthest offset back to ptr so the nearest requester wins.
      for (int off = N - 1; off >= 0; off--) begin
        idx = (int'(ptr_q) + off) % N;
        if (req[idx]) begin
          has_win = 1'b1;
          winner  = SELW'(idx);
        end
      end
    end
  end

  // Data mux for the winning channel and the one-hot grant.
  always_comb begin
    win_data = '0;
    grant    = '0;
    for (int k = 0; k < N; k++) begin
      if (winner == SELW'(k)) begin
        win_data = I[k*WIDTH +: WIDTH];
        grant[k] = fire;
      end
    end
  end

  // Next-state for the output slot and the round-robin pointer.
  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    y_ch_d    = y_ch_q;
    ptr_d     = ptr_q;
    if (load_en) begin
      if (has_win) begin
        y_d       = win_data;
        y_ch_d    = winner;
        y_valid_d = 1'b1;
        if (mode) begin
          ptr_d = (int'(winner) == N - 1) ? '0 : winner + 1'b1;
        end
      end else begin
        // Nothing to load: the slot empties, Y and Y_ch keep their last value.
        y_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset; reset discards any held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_ch_q    <= '0;
      ptr_q     <= '0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      y_ch_q    <= y_ch_d;
      ptr_q     <= ptr_d;
    end
  end

  assign Y       = y_q;
  assign Y_valid = y_valid_q;
  assign Y_ch    = y_ch_q;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Testbench for mux_nx1_rr: directed scenarios plus a randomized run checked
// against a behavioural model of the selector. A second N=3 instance covers
// the out-of-range explicit select.
module tb_mux_nx1_rr;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // N=4 instance
  logic [W-1:0]   y;
  logic           y_valid;
  logic [1:0]     y_ch;
  logic [3:0]     grant;
  logic           y_ready;
  logic           mode;
  logic [1:0]     s;
  logic [3:0]     req;
  logic [4*W-1:0] i_bus;

  // N=3 instance
  logic [W-1:0]   y3;
  logic           y3_valid;
  logic [1:0]     y3_ch;
  logic [2:0]     grant3;
  logic           y3_ready;
  logic           mode3;
  logic [1:0]     s3;
  logic [2:0]     req3;
  logic [3*W-1:0] i3_bus;

  int tests_run = 0;
  int tests_failed = 0;

  mux_nx1_rr #(.WIDTH(W), .N(4), .SELW(2)) dut (
    .clk(clk), .reset(reset), .Y(y), .Y_valid(y_valid), .Y_ch(y_ch),
    .grant(grant), .Y_ready(y_ready), .mode(mode), .s(s), .req(req), .I(i_bus)
  );

  mux_nx1_rr #(.WIDTH(W), .N(3), .SELW(2)) dut3 (
    .clk(clk), .reset(reset), .Y(y3), .Y_valid(y3_valid), .Y_ch(y3_ch),
    .grant(grant3), .Y_ready(y3_ready), .mode(mode3), .s(s3), .req(req3), .I(i3_bus)
  );

  // ---------------- driver tasks ----------------
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [W-1:0] v);
    i_bus[k*W +: W] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    edge1();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; mode = 1'b1; y_ready = 1'b1;
    #1;
    tests_run++;
    if (grant !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant0 got=%b exp=0000", grant); end
    edge1();
    tests_run++;
    if (y !== '0 || y_valid !== 1'b0 || y_ch !== 2'd0) begin
      tests_failed++; $display("FAIL reset_state y=%h v=%b ch=%0d exp 0/0/0", y, y_valid, y_ch);
    end
    tests_run++;
    if (grant !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant1 got=%b exp=0000", grant); end
    edge1();
    tests_run++;
    if (y_valid !== 1'b0 || grant !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_hold v=%b grant=%b exp 0/0000", y_valid, grant);
    end
    reset = 1'b0;
  endtask

  task automatic test_explicit();
    do_reset();
    mode = 1'b0; s = 2'd2; req = 4'b0100; set_ch(2, 32'hDEADBEEF); y_ready = 1'b1;
    #1;
    tests_run++;
    if (grant !== 4'b0100) begin tests_failed++; $display("FAIL sel_grant got=%b exp=0100", grant); end
    edge1();
    tests_run++;
    if (y !== 32'hDEADBEEF || y_ch !== 2'd2 || y_valid !== 1'b1) begin
      tests_failed++; $display("FAIL sel_out y=%h ch=%0d v=%b exp deadbeef/2/1", y, y_ch, y_valid);
    end
    req = 4'b0000;
    #1;
    tests_run++;
    if (grant !== 4'b0000) begin tests_failed++; $display("FAIL sel_noreq_grant got=%b exp=0000", grant); end
    edge1();
    tests_run++;
    if (y_valid !== 1'b0 || y !== 32'hDEADBEEF || y_ch !== 2'd2) begin
      tests_failed++; $display("FAIL sel_drop v=%b y=%h ch=%0d exp 0/deadbeef/2", y_valid, y, y_ch);
    end
    req = 4'b1011;
    #1;
    tests_run++;
    if (grant !== 4'b0000) begin tests_failed++; $display("FAIL sel_req2_low got=%b exp=0000", grant); end
    edge1();
    tests_run++;
    if (y_valid !== 1'b0) begin tests_failed++; $display("FAIL sel_req2_low_v got=%b exp=0", y_valid); end
  endtask

  task automatic test_rr();
    int seq_a[5];
    int seq_b[4];
    seq_a = '{0, 1, 2, 3, 0};
    seq_b = '{0, 3, 0, 3};
    do_reset();
    mode = 1'b1; req = 4'b1111; y_ready = 1'b1;
    for (int k = 0; k < 4; k++) set_ch(k, 32'hA000_0000 + k);
    for (int c = 0; c < 5; c++) begin
      #1;
      tests_run++;
      if (grant !== 4'(1 << seq_a[c])) begin
        tests_failed++; $display("FAIL rr_grant c=%0d got=%b exp_ch=%0d", c, grant, seq_a[c]);
      end
      edge1();
      tests_run++;
      if (y_ch !== 2'(seq_a[c]) || y !== 32'hA000_0000 + seq_a[c] || y_valid !== 1'b1) begin
        tests_failed++; $display("FAIL rr_out c=%0d ch=%0d y=%h v=%b exp_ch=%0d", c, y_ch, y, y_valid, seq_a[c]);
      end
    end
    do_reset();
    req = 4'b1001;
    for (int c = 0; c < 4; c++) begin
      #1;
      tests_run++;
      if (grant !== 4'(1 << seq_b[c])) begin
        tests_failed++; $display("FAIL rr_1001 c=%0d got=%b exp_ch=%0d", c, grant, seq_b[c]);
      end
      edge1();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b1; req = 4'b0010; set_ch(1, 32'h11); y_ready = 1'b1;
    #1;
    tests_run++;
    if (grant !== 4'b0010) begin tests_failed++; $display("FAIL bp_first_grant got=%b exp=0010", grant); end
    edge1();
    y_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++;
      if (grant !== 4'b0000) begin tests_failed++; $display("FAIL bp_stall_grant c=%0d got=%b exp=0000", c, grant); end
      edge1();
      tests_run++;
      if (y !== 32'h11 || y_valid !== 1'b1 || y_ch !== 2'd1) begin
        tests_failed++; $display("FAIL bp_hold c=%0d y=%h v=%b ch=%0d exp 11/1/1", c, y, y_valid, y_ch);
      end
    end
    y_ready = 1'b1; set_ch(1, 32'h22);
    #1;
    tests_run++;
    if (grant !== 4'b0010) begin tests_failed++; $display("FAIL bp_release_grant got=%b exp=0010", grant); end
    edge1();
    tests_run++;
    if (y !== 32'h22 || y_valid !== 1'b1) begin
      tests_failed++; $display("FAIL bp_no_bubble y=%h v=%b exp 22/1", y, y_valid);
    end
    // Pointer only moved on the two grants of channel 1, so it sits at 2.
    req = 4'b1111;
    #1;
    tests_run++;
    if (grant !== 4'b0100) begin tests_failed++; $display("FAIL bp_ptr got=%b exp=0100", grant); end
    edge1();
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 1'b1; req = 4'b1111; y_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests_run++;
      if (grant !== 4'(1 << c)) begin tests_failed++; $display("FAIL ms_rr c=%0d got=%b exp_ch=%0d", c, grant, c); end
      edge1();
    end
    mode = 1'b0; s = 2'd0; req = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests_run++;
      if (grant !== 4'b0001) begin tests_failed++; $display("FAIL ms_sel c=%0d got=%b exp=0001", c, grant); end
      edge1();
    end
    mode = 1'b1; req = 4'b1111;
    #1;
    tests_run++;
    if (grant !== 4'b0100) begin tests_failed++; $display("FAIL ms_back_rr got=%b exp=0100", grant); end
    edge1();
    // N=3: an index of 3 is out of range and must never win.
    mode3 = 1'b0; s3 = 2'd0; req3 = 3'b111; y3_ready = 1'b1; i3_bus[0 +: W] = 32'hA5;
    #1;
    tests_run++;
    if (grant3 !== 3'b001) begin tests_failed++; $display("FAIL n3_sel0 got=%b exp=001", grant3); end
    edge1();
    tests_run++;
    if (y3_valid !== 1'b1 || y3 !== 32'hA5) begin tests_failed++; $display("FAIL n3_load v=%b y=%h exp 1/a5", y3_valid, y3); end
    s3 = 2'd3;
    #1;
    tests_run++;
    if (grant3 !== 3'b000) begin tests_failed++; $display("FAIL n3_oor_grant got=%b exp=000", grant3); end
    edge1();
    tests_run++;
    if (y3_valid !== 1'b0 || y3 !== 32'hA5) begin tests_failed++; $display("FAIL n3_oor_drop v=%b y=%h exp 0/a5", y3_valid, y3); end
    req3 = 3'b000;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    mode = 1'b1; req = 4'b0010; set_ch(1, 32'h55); y_ready = 1'b1;
    edge1();
    y_ready = 1'b0;
    edge1();
    reset = 1'b1;
    #1;
    tests_run++;
    if (grant !== 4'b0000) begin tests_failed++; $display("FAIL rms_grant got=%b exp=0000", grant); end
    edge1();
    tests_run++;
    if (y_valid !== 1'b0 || y !== '0 || y_ch !== 2'd0) begin
      tests_failed++; $display("FAIL rms_state v=%b y=%h ch=%0d exp 0/0/0", y_valid, y, y_ch);
    end
    reset = 1'b0; y_ready = 1'b1; req = 4'b1111;
    #1;
    tests_run++;
    if (grant !== 4'b0001) begin tests_failed++; $display("FAIL rms_ptr got=%b exp=0001", grant); end
    edge1();
  endtask

  // Randomized run against a behavioural model: the slot is a one-entry
  // buffer, the rotation pointer is the channel after the last rr winner.
  task automatic test_random();
    logic [W-1:0] m_y;
    logic [1:0]   m_ch;
    logic         m_valid;
    int           m_ptr;
    int           w;
    logic [3:0]   exp_g;
    logic [W-1:0] exp_q[$];
    do_reset();
    m_y = '0; m_ch = '0; m_valid = 1'b0; m_ptr = 0;
    for (int c = 0; c < 400; c++) begin
      reset   = ($urandom_range(0, 31) == 0);
      mode    = 1'($urandom_range(0, 1));
      s       = 2'($urandom_range(0, 3));
      req     = 4'($urandom_range(0, 15));
      y_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) set_ch(k, $urandom);
      #1;
      w = -1;
      if (!reset && (!m_valid || y_ready)) begin
        if (!mode) begin
          if (req[s]) w = int'(s);
        end else begin
          for (int off = 0; off < 4 && w < 0; off++)
            if (req[(m_ptr + off) % 4]) w = (m_ptr + off) % 4;
        end
      end
      exp_g = (w >= 0) ? 4'(1 << w) : 4'b0000;
      tests_run++;
      if (grant !== exp_g) begin tests_failed++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, grant, exp_g); end
      if (reset) begin
        m_y = '0; m_ch = '0; m_valid = 1'b0; m_ptr = 0;
        exp_q.delete();
      end else if (!m_valid || y_ready) begin
        if (m_valid) void'(exp_q.pop_front());
        if (w >= 0) begin
          m_y = i_bus[w*W +: W]; m_ch = 2'(w); m_valid = 1'b1;
          exp_q.push_back(m_y);
          if (mode) m_ptr = (w + 1) % 4;
        end else begin
          m_valid = 1'b0;
        end
      end
      edge1();
      tests_run++;
      if (y_valid !== m_valid || y !== m_y || y_ch !== m_ch) begin
        tests_failed++;
        $display("FAIL rnd_out c=%0d v=%b y=%h ch=%0d exp %b/%h/%0d", c, y_valid, y, y_ch, m_valid, m_y, m_ch);
      end
      if (m_valid) begin
        tests_run++;
        if (exp_q.size() != 1 || y !== exp_q[0]) begin
          tests_failed++; $display("FAIL rnd_queue c=%0d y=%h queued=%0d", c, y, exp_q.size());
        end
      end
    end
    reset = 1'b0;
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    reset = 1'b1; y_ready = 1'b1; mode = 1'b0; s = '0; req = '0; i_bus = '0;
    y3_ready = 1'b1; mode3 = 1'b0; s3 = '0; req3 = '0; i3_bus = '0;
    test_reset();
    test_explicit();
    test_rr();
    test_backpressure();
    test_mode_switch();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Parametrised N:1 registered datapath selector, the multi-channel successor of the 2:1 operand mux. It sits between several producers (register-file ports, immediate path, forwarding paths) and one consuming pipeline stage. It picks one channel per cycle, either by explicit select or by round-robin arbitration over requesting channels. The result goes into a single output register with a valid/ready handshake, so the consumer can stall the selector without losing data.

## Interface
Parameters:
- WIDTH, 32, data width per channel.
- N, 4, number of input channels (2..16).
- SELW, 2, select/channel-index width; must equal clog2(N) (N=2 gives 1).

Ports (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset. Sampled only on the rising edge of clk.
- Y  output  WIDTH  registered selected data.
- Y_valid  output  1  Y holds a valid word.
- Y_ch  output  SELW  channel index that produced the current Y.
- grant  output  N  combinational one-hot; grant[k]=1 in the cycle channel k's word is captured.
- Y_ready  input  1  consumer accepts Y in any cycle where Y_valid && Y_ready.
- mode  input  1  0 = explicit select via s; 1 = round-robin over req.
- s  input  SELW  explicit channel select (mode 0 only).
- req  input  N  per-channel "word available".
- I  input  N*WIDTH  flattened channel data; channel k = I[k*WIDTH +: WIDTH].

## Operation
- load_en = !Y_valid || Y_ready. The slot is empty, or it is being drained this cycle.
- Winner selection (combinational):
  - mode 0: winner = s if s < N and req[s]=1; otherwise no winner. If s >= N, there is never a winner.
  - mode 1: scan channels ptr, ptr+1, …, wrapping modulo N. The winner is the first channel with req=1. If req=0, there is no winner.
- When load_en and a winner exists:
  - grant[winner]=1.
  - Next edge: Y<=I[winner], Y_ch<=winner, Y_valid<=1.
- When load_en and there is no winner:
  - grant=0.
  - Next edge: Y_valid<=0; Y and Y_ch hold.
- When !load_en (stall): grant=0, and Y, Y_ch and Y_valid all hold.
- Round-robin pointer ptr (SELW bits, internal):
  - In mode 1, on a granted cycle, ptr<=(winner+1) mod N. Wrap: winner=N-1 gives ptr=0.
  - ptr does not change in mode 0 or on non-granted cycles.
- mode may change on any cycle. The new mode governs that cycle's selection, and ptr is preserved across mode changes.
- grant is one-hot or zero; never more than one bit is set.

## Timing
- Latency: a word captured in cycle t (grant high in t) appears on Y with Y_valid=1 in cycle t+1.
- Throughput: one word per cycle while Y_ready=1.
- Stall hold: while Y_valid=1 and Y_ready=0, Y and Y_ch are stable and grant=0.
- Simultaneous drain and fill: Y_valid=1, Y_ready=1 and a winner all in the same cycle. The old word is consumed and the new word loads on the same edge; there is no bubble.
- Reset (synchronous): at the edge where reset=1, Y<=0, Y_ch<=0, Y_valid<=0, ptr<=0.
  - grant is forced to 0 in any cycle where reset=1.
  - A reset asserted mid-stall discards the held word. It is not delivered.
- First cycle after reset deassertion: normal operation, with load_en=1 because the slot is empty.
- Producers must hold req[k] and I[k] until they see grant[k]. The block keeps no record of a request that was not granted.

## Test plan
Use N=4, WIDTH=32.
1. **Reset:** assert reset for 2 cycles with req=4'b1111 and mode=1 -> grant=0 throughout; after the first edge, Y=0, Y_valid=0, Y_ch=0.
2. **Explicit select:** mode=0, s=2, req=4'b0100, I[2]=0xDEADBEEF, Y_ready=1 -> grant=4'b0100 in cycle t; Y=0xDEADBEEF, Y_ch=2, Y_valid=1 in t+1. Then set req=0 -> Y_valid=0 in t+2 while Y stays 0xDEADBEEF. Separately, req[2]=0 with s=2 -> no grant.
3. **Round-robin fairness and wrap:** mode=1, req=4'b1111 constant, Y_ready=1 -> grant sequence 0,1,2,3,0 on consecutive cycles; Y_ch follows one cycle later. With req=4'b1001 starting from ptr=0 -> grants alternate 0,3,0,3.
4. **Backpressure:** mode=1, req=4'b0010, I[1]=0x11, Y_ready=0 for 3 cycles after Y_valid -> Y=0x11 held stable, grant=0, ptr unchanged. Raise Y_ready with I[1]=0x22 -> 0x11 is consumed and Y=0x22 on the next edge, with no bubble.
5. **Mode switch and out-of-range select:** after round-robin grants 0 and 1 (ptr=2), switch to mode=0 with s=0 for 2 grants, then back to mode=1 with req=4'b1111 -> the next round-robin grant is channel 2. For N=3, mode=0, s=3 -> grant=0 and Y_valid drops.
6. **Reset mid-stall:** Y_valid=1, Y_ready=0, then reset=1 for one cycle -> Y_valid=0, Y=0 and ptr=0 after that edge. The held word never handshakes.
